// File: rtl/crcu_clk_pkg.sv
// ---------------------------------------------------------------------------
// crcu_clk_pkg
// Shared definitions for the CRCU clock-control generator:
//   - selector codes and control-word field positions
//   - divisor lookup (selector -> terminal count N-1, plus a valid flag)
//   - per-channel FSM state encoding
// ---------------------------------------------------------------------------
package crcu_clk_pkg;

  // Control word field positions (bits above GATE_BIT are ignored)
  localparam int SEL_LSB  = 0;
  localparam int SEL_MSB  = 2;
  localparam int EN_BIT   = 3;
  localparam int GATE_BIT = 4;

  // Selector codes; the name gives the output frequency from a 1200 MHz source
  typedef enum logic [2:0] {
    SEL_100M = 3'b000,
    SEL_400M = 3'b001,
    SEL_600M = 3'b010,
    SEL_300M = 3'b011,
    SEL_200M = 3'b100
  } sel_code_e;

  // Per-channel FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } ch_state_e;

  // Lookup result: the divisor is carried as its terminal count (N-1) so
  // the counter compares against it directly
  typedef struct packed {
    logic       valid;
    logic [4:0] tc;
  } div_lut_t;

  // Reserved codes return valid=0 and a don't-care terminal count of 0
  function automatic div_lut_t divLookup(input logic [2:0] sel);
    div_lut_t res;
    res.valid = 1'b1;
    res.tc    = 5'd0;
    case (sel)
      SEL_100M: res.tc = 5'd11;
      SEL_400M: res.tc = 5'd2;
      SEL_600M: res.tc = 5'd1;
      SEL_300M: res.tc = 5'd3;
      SEL_200M: res.tc = 5'd5;
      default:  res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/crcu_clk_ctl_gen_div_ch.sv
// ---------------------------------------------------------------------------
// crcu_clk_div_ch
// One clock channel: control-field storage, IDLE/RUN/DRAIN FSM, divider
// counter and registered outputs. Divisor and run changes are only applied
// at the end of a full period, so phases are never truncated.
// Ports:
//   i_clk      source clock (rising edge)
//   i_rst_n    synchronous active-low reset
//   i_ctl      control fields {gate, enable, sel[2:0]}
//   i_wr_en    one-cycle write strobe for i_ctl
//   o_clk      divided clock
//   o_pulse    one-cycle pulse at each period start
//   o_active   channel in RUN or DRAIN
//   o_busy     channel in DRAIN
//   o_selErr   last write used a reserved selector (sticky until next write)
// ---------------------------------------------------------------------------
module crcu_clk_div_ch
  import crcu_clk_pkg::*;
#(
  parameter int         CNT_W   = 4,
  parameter logic [2:0] RST_SEL = 3'b000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [GATE_BIT:0] i_ctl,
  input  logic            i_wr_en,
  output logic            o_clk,
  output logic            o_pulse,
  output logic            o_active,
  output logic            o_busy,
  output logic            o_selErr
);

  localparam div_lut_t         RST_LUT = divLookup(RST_SEL);
  localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RST_LUT.tc);

  ch_state_e        r_state, w_stateNxt;
  logic [CNT_W-1:0] r_cnt, w_cntNxt;
  logic [CNT_W-1:0] r_tc, w_tcNxt;
  logic [CNT_W-1:0] r_pendTc, w_pendTcNxt;
  logic             r_runReq, w_runReqNxt;
  logic             r_selErr, w_selErrNxt;
  logic             r_clk, r_pulse, r_active, r_busy;

  div_lut_t         w_lut;
  logic [CNT_W-1:0] w_wrTc;
  logic             w_wrRun;
  logic             w_wrap;
  logic [CNT_W:0]   w_halfNxt;
  logic             w_activeNxt;

  // Decode the incoming write; a reserved selector keeps the stored divisor
  assign w_lut   = divLookup(i_ctl[SEL_MSB:SEL_LSB]);
  assign w_wrTc  = w_lut.valid ? CNT_W'(w_lut.tc) : r_pendTc;
  assign w_wrRun = i_ctl[EN_BIT] & ~i_ctl[GATE_BIT];
  assign w_wrap  = (r_cnt == r_tc);

  // Next-state logic. r_pendTc/r_runReq always hold the latest written
  // fields; r_tc is the divisor actually in use and only changes on entry
  // to RUN from IDLE or at the final cycle of a DRAIN period.
  always_comb begin
    w_stateNxt  = r_state;
    w_cntNxt    = r_cnt;
    w_tcNxt     = r_tc;
    w_pendTcNxt = r_pendTc;
    w_runReqNxt = r_runReq;
    w_selErrNxt = r_selErr;

    if (i_wr_en) begin
      w_pendTcNxt = w_wrTc;
      w_runReqNxt = w_wrRun;
      w_selErrNxt = ~w_lut.valid;
    end

    case (r_state)
      IDLE: begin
        w_cntNxt = '0;
        if (i_wr_en && w_wrRun) begin
          w_tcNxt    = w_wrTc;
          w_stateNxt = RUN;
        end
      end
      RUN: begin
        w_cntNxt = w_wrap ? '0 : r_cnt + 1'b1;
        if (i_wr_en && ((w_wrTc != r_tc) || !w_wrRun))
          w_stateNxt = DRAIN;
      end
      DRAIN: begin
        w_cntNxt = w_wrap ? '0 : r_cnt + 1'b1;
        if (w_wrap) begin
          w_tcNxt    = w_pendTcNxt;
          w_stateNxt = w_runReqNxt ? RUN : IDLE;
        end
      end
      default: begin
        w_cntNxt   = '0;
        w_stateNxt = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so that, once registered,
  // they line up with the counter value of the same cycle. High phase is
  // floor(N/2) cycles with N = tc + 1.
  assign w_activeNxt = (w_stateNxt != IDLE);
  assign w_halfNxt   = ({1'b0, w_tcNxt} + 1'b1) >> 1;

  // State register and registered outputs, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tc     <= RST_TC;
      r_pendTc <= RST_TC;
      r_runReq <= 1'b0;
      r_selErr <= 1'b0;
      r_clk    <= 1'b0;
      r_pulse  <= 1'b0;
      r_active <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_stateNxt;
      r_cnt    <= w_cntNxt;
      r_tc     <= w_tcNxt;
      r_pendTc <= w_pendTcNxt;
      r_runReq <= w_runReqNxt;
      r_selErr <= w_selErrNxt;
      r_clk    <= w_activeNxt && ({1'b0, w_cntNxt} < w_halfNxt);
      r_pulse  <= w_activeNxt && (w_cntNxt == '0);
      r_active <= w_activeNxt;
      r_busy   <= (w_stateNxt == DRAIN);
    end
  end

  assign o_clk    = r_clk;
  assign o_pulse  = r_pulse;
  assign o_active = r_active;
  assign o_busy   = r_busy;
  assign o_selErr = r_selErr;

endmodule

// File: rtl/crcu_clk_ctl_gen.sv
// ---------------------------------------------------------------------------
// crcu_clk_ctl_gen
// Multi-channel clock-control generator. Each channel divides CRCU_CLK by a
// divisor chosen through its 32-bit control word; all channels are
// independent and may be written in the same cycle.
// Ports:
//   CRCU_CLK      source clock
//   CRCU_RST_N    synchronous active-low reset
//   ctl_reg       NUM_CH x 32-bit control words, channel i at [32*i +: 32]
//   ctl_wr_en     per-channel write strobe
//   clk_out       divided clocks
//   clk_en_pulse  period-start pulses
//   ch_active     channel in RUN or DRAIN
//   ch_busy       channel in DRAIN
//   sel_err       last write used a reserved selector
// ---------------------------------------------------------------------------
module crcu_clk_ctl_gen
  import crcu_clk_pkg::*;
#(
  parameter int         NUM_CH  = 4,
  parameter int         CNT_W   = 4,
  parameter logic [2:0] RST_SEL = 3'b000
) (
  input  logic                CRCU_CLK,
  input  logic                CRCU_RST_N,
  input  logic [NUM_CH*32-1:0] ctl_reg,
  input  logic [NUM_CH-1:0]   ctl_wr_en,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   clk_en_pulse,
  output logic [NUM_CH-1:0]   ch_active,
  output logic [NUM_CH-1:0]   ch_busy,
  output logic [NUM_CH-1:0]   sel_err
);

  // Upper control-word bits carry no function; fold them so they are
  // visibly consumed
  logic w_unusedCtl;
  assign w_unusedCtl = ^ctl_reg;

  // One independent channel per control word
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    crcu_clk_div_ch #(
      .CNT_W   (CNT_W),
      .RST_SEL (RST_SEL)
    ) u_ch (
      .i_clk    (CRCU_CLK),
      .i_rst_n  (CRCU_RST_N),
      .i_ctl    (ctl_reg[32*gi +: GATE_BIT+1]),
      .i_wr_en  (ctl_wr_en[gi]),
      .o_clk    (clk_out[gi]),
      .o_pulse  (clk_en_pulse[gi]),
      .o_active (ch_active[gi]),
      .o_busy   (ch_busy[gi]),
      .o_selErr (sel_err[gi])
    );
  end

endmodule

// File: tb/tb_crcu_clk_ctl_gen.sv
// ---------------------------------------------------------------------------
// tb_crcu_clk_ctl_gen
// Directed bench for the clock-control generator. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_crcu_clk_ctl_gen;

  localparam int NUM_CH = 4;

  logic                  CRCU_CLK;
  logic                  CRCU_RST_N;
  logic [NUM_CH*32-1:0]  ctl_reg;
  logic [NUM_CH-1:0]     ctl_wr_en;
  logic [NUM_CH-1:0]     clk_out;
  logic [NUM_CH-1:0]     clk_en_pulse;
  logic [NUM_CH-1:0]     ch_active;
  logic [NUM_CH-1:0]     ch_busy;
  logic [NUM_CH-1:0]     sel_err;

  int testsRun    = 0;
  int testsFailed = 0;

  crcu_clk_ctl_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (4),
    .RST_SEL (3'b000)
  ) dut (
    .CRCU_CLK     (CRCU_CLK),
    .CRCU_RST_N   (CRCU_RST_N),
    .ctl_reg      (ctl_reg),
    .ctl_wr_en    (ctl_wr_en),
    .clk_out      (clk_out),
    .clk_en_pulse (clk_en_pulse),
    .ch_active    (ch_active),
    .ch_busy      (ch_busy),
    .sel_err      (sel_err)
  );

  // Free-running source clock
  initial CRCU_CLK = 1'b0;
  always #5 CRCU_CLK = ~CRCU_CLK;

  // Watchdog so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Write one channel's control word for one cycle; returns at the first
  // falling edge after the write edge
  task automatic applyStimulus(input int ch, input logic [31:0] data);
    ctl_reg[32*ch +: 32] = data;
    ctl_wr_en[ch]        = 1'b1;
    @(posedge CRCU_CLK);
    #1;
    ctl_wr_en = '0;
    @(negedge CRCU_CLK);
  endtask

  // Sync to the next rising sample of clk_out[ch], then measure one full
  // high/low period and the pulses inside it. Ends on the next rising sample.
  task automatic measurePhases(input int ch, output int hi, output int lo,
                               output int pulses);
    int guard;
    hi = 0; lo = 0; pulses = 0;
    guard = 0;
    while (clk_out[ch] && guard < 64) begin guard++; @(negedge CRCU_CLK); end
    guard = 0;
    while (!clk_out[ch] && guard < 64) begin guard++; @(negedge CRCU_CLK); end
    while (clk_out[ch] && hi < 64) begin
      hi++;
      if (clk_en_pulse[ch]) pulses++;
      @(negedge CRCU_CLK);
    end
    while (!clk_out[ch] && lo < 64) begin
      lo++;
      if (clk_en_pulse[ch]) pulses++;
      @(negedge CRCU_CLK);
    end
  endtask

  // Count consecutive busy samples on a channel, splitting clk high/low
  task automatic countBusy(input int ch, output int n, output int hi,
                           output int lo);
    n = 0; hi = 0; lo = 0;
    while (ch_busy[ch] && n < 64) begin
      n++;
      if (clk_out[ch]) hi++; else lo++;
      @(negedge CRCU_CLK);
    end
  endtask

  initial begin
    int hi, lo, pulses, n, acc;

    CRCU_RST_N = 1'b0;
    ctl_reg    = '0;
    ctl_wr_en  = '0;
    repeat (3) @(posedge CRCU_CLK);
    @(negedge CRCU_CLK);
    checkOutput("rst_clk_out", 32'(clk_out), 0);
    checkOutput("rst_pulse",   32'(clk_en_pulse), 0);
    checkOutput("rst_active",  32'(ch_active), 0);
    checkOutput("rst_busy",    32'(ch_busy), 0);
    checkOutput("rst_sel_err", 32'(sel_err), 0);
    CRCU_RST_N = 1'b1;

    // ch0: sel 000, enable -> N=12
    $display("[TB] ch0 start N=12");
    applyStimulus(0, 32'h08);
    checkOutput("ch0_first_clk",    32'(clk_out[0]), 1);
    checkOutput("ch0_first_pulse",  32'(clk_en_pulse[0]), 1);
    checkOutput("ch0_active",       32'(ch_active[0]), 1);
    measurePhases(0, hi, lo, pulses);
    checkOutput("ch0_n12_hi",     hi, 6);
    checkOutput("ch0_n12_lo",     lo, 6);
    checkOutput("ch0_n12_pulses", pulses, 1);

    // ch0: switch to sel 010 (N=2) while cnt=3
    $display("[TB] ch0 switch to N=2");
    repeat (3) @(negedge CRCU_CLK);
    applyStimulus(0, 32'h0A);
    countBusy(0, n, hi, lo);
    checkOutput("ch0_drain_len", n, 8);
    checkOutput("ch0_drain_hi",  hi, 2);
    checkOutput("ch0_drain_lo",  lo, 6);
    checkOutput("ch0_new_clk",   32'(clk_out[0]), 1);
    checkOutput("ch0_new_pulse", 32'(clk_en_pulse[0]), 1);
    measurePhases(0, hi, lo, pulses);
    checkOutput("ch0_n2_hi", hi, 1);
    checkOutput("ch0_n2_lo", lo, 1);

    // ch1: N=3 then gate
    $display("[TB] ch1 N=3 then gate");
    applyStimulus(1, 32'h09);
    checkOutput("ch1_first_clk", 32'(clk_out[1]), 1);
    measurePhases(1, hi, lo, pulses);
    checkOutput("ch1_n3_hi", hi, 1);
    checkOutput("ch1_n3_lo", lo, 2);
    applyStimulus(1, 32'h19);
    countBusy(1, n, hi, lo);
    checkOutput("ch1_drain_len", n, 2);
    checkOutput("ch1_drain_hi",  hi, 0);
    checkOutput("ch1_idle_active", 32'(ch_active[1]), 0);
    checkOutput("ch1_idle_clk",    32'(clk_out[1]), 0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (clk_out[1] || clk_en_pulse[1]) acc++;
      @(negedge CRCU_CLK);
    end
    checkOutput("ch1_stays_quiet", acc, 0);

    // ch2: N=4, reserved write, then sel 100
    $display("[TB] ch2 reserved selector handling");
    applyStimulus(2, 32'h0B);
    measurePhases(2, hi, lo, pulses);
    checkOutput("ch2_n4_hi", hi, 2);
    checkOutput("ch2_n4_lo", lo, 2);
    applyStimulus(2, 32'h0F);
    checkOutput("ch2_sel_err_set", 32'(sel_err[2]), 1);
    checkOutput("ch2_no_drain",    32'(ch_busy[2]), 0);
    measurePhases(2, hi, lo, pulses);
    checkOutput("ch2_kept_hi", hi, 2);
    checkOutput("ch2_kept_lo", lo, 2);
    applyStimulus(2, 32'h0C);
    checkOutput("ch2_sel_err_clr", 32'(sel_err[2]), 0);
    checkOutput("ch2_busy",        32'(ch_busy[2]), 1);
    measurePhases(2, hi, lo, pulses);
    checkOutput("ch2_n6_hi", hi, 3);
    checkOutput("ch2_n6_lo", lo, 3);

    // ch3: two writes inside one drain, last one wins
    $display("[TB] ch3 double write in drain");
    applyStimulus(3, 32'h08);
    applyStimulus(3, 32'h09);
    checkOutput("ch3_busy1", 32'(ch_busy[3]), 1);
    repeat (2) @(negedge CRCU_CLK);
    applyStimulus(3, 32'h0B);
    checkOutput("ch3_busy2", 32'(ch_busy[3]), 1);
    measurePhases(3, hi, lo, pulses);
    checkOutput("ch3_n4_hi", hi, 2);
    checkOutput("ch3_n4_lo", lo, 2);
    checkOutput("ch3_not_busy", 32'(ch_busy[3]), 0);

    // Reset mid-high on ch2, then restart ch0 with a reserved selector so
    // the reset divisor (N=12) is what runs
    $display("[TB] mid-operation reset");
    n = 0;
    while (clk_out[2] && n < 64) begin n++; @(negedge CRCU_CLK); end
    n = 0;
    while (!clk_out[2] && n < 64) begin n++; @(negedge CRCU_CLK); end
    @(negedge CRCU_CLK);
    checkOutput("pre_rst_active", 32'(ch_active), 32'hD);
    CRCU_RST_N = 1'b0;
    @(posedge CRCU_CLK);
    @(negedge CRCU_CLK);
    checkOutput("mrst_clk_out", 32'(clk_out), 0);
    checkOutput("mrst_pulse",   32'(clk_en_pulse), 0);
    checkOutput("mrst_active",  32'(ch_active), 0);
    checkOutput("mrst_busy",    32'(ch_busy), 0);
    checkOutput("mrst_sel_err", 32'(sel_err), 0);
    CRCU_RST_N = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if ((clk_out != '0) || (ch_active != '0)) acc++;
      @(negedge CRCU_CLK);
    end
    checkOutput("post_rst_idle", acc, 0);
    applyStimulus(0, 32'h0D);
    checkOutput("restart_sel_err", 32'(sel_err[0]), 1);
    checkOutput("restart_clk",     32'(clk_out[0]), 1);
    measurePhases(0, hi, lo, pulses);
    checkOutput("restart_hi", hi, 6);
    checkOutput("restart_lo", lo, 6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
